// File: rtl/fwrisc_fetch.sv
// rtl/fwrisc_fetch.sv - RV32C-aware instruction fetch with half-word realignment
module fwrisc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic [31:0] idata,
  input  logic        iready,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    FETCH0 = 2'd0,
    FETCH1 = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] hbuf;
  logic [15:0] hbuf_nxt;
  logic        hbuf_valid;
  logic        hbuf_valid_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  logic [31:0] instr_nxt;
  logic        instr_c_nxt;
  logic        fetch_valid_nxt;
  logic        complete;
  logic [15:0] lo_half;
  logic [15:0] hi_half;

  // Any half-word whose two low bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_c(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign complete = ivalid && iready;
  assign lo_half  = idata[15:0];
  assign hi_half  = idata[31:16];
  assign pc_inc   = pc + (instr_c ? 32'd2 : 32'd4);

  // Memory request: FETCH1 always targets the word after the one holding pc.
  always_comb begin
    ivalid = !reset && (state != HOLD);
    if (state == FETCH1) begin
      iaddr = {pc[31:2] + 30'd1, 2'b00};
    end else begin
      iaddr = {pc[31:2], 2'b00};
    end
  end

  // Next-state and next-output logic; redirect overrides everything else.
  always_comb begin
    state_nxt       = state;
    hbuf_nxt        = hbuf;
    hbuf_valid_nxt  = hbuf_valid;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_c_nxt     = instr_c;
    fetch_valid_nxt = fetch_valid;

    if (redirect_valid) begin
      pc_nxt          = {redirect_pc[31:1], 1'b0};
      hbuf_valid_nxt  = 1'b0;
      fetch_valid_nxt = 1'b0;
      state_nxt       = FETCH0;
    end else begin
      case (state)
        FETCH0: begin
          if (complete) begin
            if (!pc[1]) begin
              if (is_c(lo_half)) begin
                // Keep the upper half; it may be the next instruction.
                instr_nxt      = {16'h0, lo_half};
                instr_c_nxt    = 1'b1;
                hbuf_nxt       = hi_half;
                hbuf_valid_nxt = 1'b1;
              end else begin
                instr_nxt   = idata;
                instr_c_nxt = 1'b0;
              end
              fetch_valid_nxt = 1'b1;
              state_nxt       = HOLD;
            end else if (is_c(hi_half)) begin
              instr_nxt       = {16'h0, hi_half};
              instr_c_nxt     = 1'b1;
              fetch_valid_nxt = 1'b1;
              state_nxt       = HOLD;
            end else begin
              // 32-bit instruction straddles into the next word.
              hbuf_nxt  = hi_half;
              state_nxt = FETCH1;
            end
          end
        end

        FETCH1: begin
          if (complete) begin
            instr_nxt       = {lo_half, hbuf};
            instr_c_nxt     = 1'b0;
            hbuf_nxt        = hi_half;
            hbuf_valid_nxt  = 1'b1;
            fetch_valid_nxt = 1'b1;
            state_nxt       = HOLD;
          end
        end

        HOLD: begin
          if (decode_ready) begin
            pc_nxt = pc_inc;
            if (hbuf_valid && pc_inc[1] && is_c(hbuf)) begin
              // Buffered compressed instruction: present it back-to-back.
              instr_nxt      = {16'h0, hbuf};
              instr_c_nxt    = 1'b1;
              hbuf_valid_nxt = 1'b0;
            end else if (hbuf_valid && pc_inc[1]) begin
              // Buffer holds the low half of a straddling instruction.
              fetch_valid_nxt = 1'b0;
              state_nxt       = FETCH1;
            end else begin
              hbuf_valid_nxt  = 1'b0;
              fetch_valid_nxt = 1'b0;
              state_nxt       = FETCH0;
            end
          end
        end

        default: begin
          state_nxt = FETCH0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH0;
      pc          <= RESET_VECTOR;
      hbuf        <= 16'h0;
      hbuf_valid  <= 1'b0;
      instr       <= 32'h0;
      instr_c     <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      hbuf        <= hbuf_nxt;
      hbuf_valid  <= hbuf_valid_nxt;
      instr       <= instr_nxt;
      instr_c     <= instr_c_nxt;
      fetch_valid <= fetch_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fwrisc_fetch.sv
// tb/tb_fwrisc_fetch.sv - bench for fwrisc_fetch: directed cases plus scoreboarded random run
module tb_fwrisc_fetch;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] instr;
  logic        instr_c;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  // 1 KiB instruction memory, aliased across the address space by iaddr[9:2].
  logic [31:0] mem [0:255];
  assign idata = mem[iaddr[9:2]];

  fwrisc_fetch #(.RESET_VECTOR(RV)) dut (
    .clock          (clock),
    .reset          (reset),
    .iaddr          (iaddr),
    .ivalid         (ivalid),
    .idata          (idata),
    .iready         (iready),
    .fetch_valid    (fetch_valid),
    .decode_ready   (decode_ready),
    .instr          (instr),
    .instr_c        (instr_c),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic        have_cur = 1'b0;
  logic        sb_on    = 1'b0;
  int          idle     = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: the instruction at byte address a, read straight from memory.
  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic exp_t ref_at(input logic [31:0] a);
    exp_t        e;
    logic [15:0] h0;
    logic [15:0] h1;
    h0   = half_at(a);
    h1   = half_at(a + 32'd2);
    e.pc = a;
    if (h0[1:0] != 2'b11) begin
      e.instr = {16'h0, h0};
      e.c     = 1'b1;
    end else begin
      e.instr = {h1, h0};
      e.c     = 1'b0;
    end
    return e;
  endfunction

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  // Monitor: pops one expectation per presented instruction and checks it stays put.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (sb_on) begin
        if (fetch_valid) begin
          idle = 0;
          chk("no_prefetch", {31'b0, ivalid}, 32'h0);
          if (!have_cur) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_empty actual_pc=%h required=none", pc);
            end else begin
              cur = exp_q.pop_front();
              chk("sb_pc", pc, cur.pc);
              chk("sb_instr", instr, cur.instr);
              chk("sb_c", {31'b0, instr_c}, {31'b0, cur.c});
              have_cur = 1'b1;
            end
          end else begin
            chk("hold_pc", pc, cur.pc);
            chk("hold_instr", instr, cur.instr);
            chk("hold_c", {31'b0, instr_c}, {31'b0, cur.c});
          end
        end else begin
          idle++;
          if (idle > 200) begin
            total++;
            bad++;
            $display("FAIL timeout actual=no_fetch_valid required=fetch_valid pc=%h", pc);
            idle = 0;
          end
        end
      end
      #2;
      if (sb_on && (redirect_valid || (fetch_valid && decode_ready))) begin
        have_cur = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    iready         = 1'b0;
    decode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]     = 32'h0000_0537;
    mem[1]     = 32'h4501_4505;
    mem[2]     = 32'h0537_4505;
    mem[3]     = 32'h0001_0000;
    mem[8'h40] = 32'h1234_4505;
    mem[8'h41] = 32'h0537_0000;

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ivalid", {31'b0, ivalid}, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pc", pc, RV);
    chk("rst_instr", instr, 32'h0);
    chk("rst_c", {31'b0, instr_c}, 32'h0);
    reset = 1'b0;
    #1;
    chk("first_ivalid", {31'b0, ivalid}, 32'h1);
    chk("first_iaddr", iaddr, RV);
    iready       = 1'b1;
    decode_ready = 1'b1;

    // Aligned 32-bit.
    nxt();
    chk("lui_fv", {31'b0, fetch_valid}, 32'h1);
    chk("lui_instr", instr, 32'h0000_0537);
    chk("lui_c", {31'b0, instr_c}, 32'h0);
    chk("lui_pc", pc, RV);
    nxt();
    chk("lui_next_fv", {31'b0, fetch_valid}, 32'h0);
    chk("lui_next_iaddr", iaddr, 32'h8000_0004);

    // Two compressed in one word, second presented back-to-back.
    nxt();
    chk("c0_instr", instr, 32'h0000_4505);
    chk("c0_pc", pc, 32'h8000_0004);
    chk("c0_c", {31'b0, instr_c}, 32'h1);
    nxt();
    chk("c1_fv", {31'b0, fetch_valid}, 32'h1);
    chk("c1_instr", instr, 32'h0000_4501);
    chk("c1_pc", pc, 32'h8000_0006);
    chk("c1_no_req", {31'b0, ivalid}, 32'h0);
    nxt();
    chk("w2_iaddr", iaddr, 32'h8000_0008);

    // Memory stall with iaddr held.
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("stall_iaddr", iaddr, 32'h8000_0008);
      chk("stall_fv", {31'b0, fetch_valid}, 32'h0);
    end
    iready = 1'b1;

    // Straddle.
    nxt();
    chk("s0_instr", instr, 32'h0000_4505);
    chk("s0_pc", pc, 32'h8000_0008);
    nxt();
    chk("s_fetch1_fv", {31'b0, fetch_valid}, 32'h0);
    chk("s_fetch1_iaddr", iaddr, 32'h8000_000C);
    nxt();
    chk("s1_fv", {31'b0, fetch_valid}, 32'h1);
    chk("s1_instr", instr, 32'h0000_0537);
    chk("s1_pc", pc, 32'h8000_000A);
    chk("s1_c", {31'b0, instr_c}, 32'h0);

    // Decode stall, then exactly one accept.
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("dstall_fv", {31'b0, fetch_valid}, 32'h1);
      chk("dstall_instr", instr, 32'h0000_0537);
      chk("dstall_pc", pc, 32'h8000_000A);
    end
    decode_ready = 1'b1;
    nxt();
    decode_ready = 1'b0;
    chk("one_acc_instr", instr, 32'h0000_0001);
    chk("one_acc_pc", pc, 32'h8000_000E);
    nxt();
    chk("one_acc_hold_pc", pc, 32'h8000_000E);

    // Redirect coinciding with an accept.
    decode_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    nxt();
    redirect_valid = 1'b0;
    decode_ready   = 1'b0;
    chk("redir_fv", {31'b0, fetch_valid}, 32'h0);
    chk("redir_iaddr", iaddr, 32'h8000_0100);
    chk("redir_pc", pc, 32'h8000_0102);
    nxt();
    chk("redir_instr", instr, 32'h0000_1234);
    chk("redir_c", {31'b0, instr_c}, 32'h1);

    // Reset in the middle of FETCH1.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0106;
    nxt();
    redirect_valid = 1'b0;
    chk("r2_iaddr", iaddr, 32'h8000_0104);
    nxt();
    chk("f1_iaddr", iaddr, 32'h8000_0108);
    iready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_ivalid", {31'b0, ivalid}, 32'h0);
    chk("async_fv", {31'b0, fetch_valid}, 32'h0);
    chk("async_pc", pc, RV);
    chk("async_instr", instr, 32'h0);
    chk("async_c", {31'b0, instr_c}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("restart_ivalid", {31'b0, ivalid}, 32'h1);
    chk("restart_iaddr", iaddr, RV);

    // Random phase against the scoreboard.
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    @(negedge clock);
    reset = 1'b0;
    #2;
    exp_q.delete();
    model_pc = RV;
    exp_q.push_back(ref_at(model_pc));
    have_cur = 1'b0;
    idle     = 0;
    sb_on    = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      #2;
      iready         = ($urandom_range(0, 3) != 0);
      decode_ready   = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = RV | 32'($urandom_range(0, 1023));
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:1], 1'b0};
        exp_q.push_back(ref_at(model_pc));
      end else if (fetch_valid && decode_ready) begin
        e        = ref_at(model_pc);
        model_pc = model_pc + (e.c ? 32'd2 : 32'd4);
        exp_q.push_back(ref_at(model_pc));
      end
    end
    @(negedge clock);
    sb_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
